serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single registered full-adder cell. It is the sequencing stage that feeds the one-bit full-adder datapath. Operands are accepted over a valid/ready handshake and processed LSB-first, one bit per clock, with the carry held in a flip-flop between bits. The result is then presented on a held valid/ready output port. It trades WIDTH cycles of latency for one-bit adder hardware.

---
 rtl/serial_adder_if.sv | 43 ++++
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   in_valid/in_ready  : operand handshake (A, B, Cin, and Sub when SERIAL_ADDER_SUB_EN)
//   out_valid/out_ready: result handshake (Sum, Carry)
//   busy               : adder is in SHIFT or DONE
// Modports: master drives operands and consumes results; slave is the adder.
// Macro SERIAL_ADDER_SUB_EN adds the Sub select signal.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             Sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Carry, busy
  );
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Carry, busy
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry, busy
  );
  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry, busy
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands are accepted in IDLE, summed LSB-first one bit per clock in SHIFT with
// the carry held in a flop, and the result is held in DONE until accepted.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if.slave (operand and result handshakes, busy)
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds Sub; Sub=1 computes A - B).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_if.slave     bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // The single full-adder cell.
  logic fa_sum, fa_cout;
  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Cin;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's complement subtract: A + ~B + 1.
          if (bus.Sub) begin
            b_d     = ~bus.B;
            carry_d = 1'b1;
          end
`endif
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Sum bits enter at the MSB so bit i lands at Sum[i] after WIDTH shifts.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        // Hold the counter on the last bit so it never wraps.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.Sum       = sum_q;
  assign bus.Carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the (WIDTH+1)-bit result.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    int unsigned r;
    if (sub) r = int'(a) + (1 << W) - int'(b);
    else     r = int'(a) + int'(b) + int'(cin);
    return r[W:0];
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.Sub = sub;
`else
    if (sub) $display("sub requested without subtract support");
`endif
  endtask

  // One complete transaction; hold = cycles of out_ready low while out_valid is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int hold, input string tag);
    logic [W:0] exp;
    int         lat;
    int         guard;
    exp = model(a, b, cin, sub);
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    drive_ops(a, b, cin, sub);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.out_valid && lat < 4 * W) begin
      // Scramble inputs and poke in_valid; none of it may be taken.
      bus.in_valid = 1'($urandom);
      drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 64'(lat), 64'(W));
    check({tag, ".sum"}, 64'(bus.Sum), 64'(exp[W-1:0]));
    check({tag, ".carry"}, 64'(bus.Carry), 64'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, ".hold_sum"}, 64'({bus.Carry, bus.Sum}), 64'(exp));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, ".post_held"}, 64'({bus.Carry, bus.Sum}), 64'(exp));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.sum", 64'(bus.Sum), 64'h00);
    check("rst.carry", 64'(bus.Carry), 64'd0);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, "d0f01");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "dff01");
    run_op(8'hAA, 8'h55, 1'b1, 1'b0, 0, "daa55");
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 5, "d1234");

    // Reset three cycles into SHIFT.
    @(negedge clk);
    drive_ops(8'h77, 8'h66, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst.busy", 64'(bus.busy), 64'd0);
    check("mrst.sum", 64'({bus.Carry, bus.Sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, "d0101");

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, "sub0507");
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 1, "sub0705");
`endif

    for (int i = 0; i < 20; i++) begin
      logic sub_r;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), sub_r,
             int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
